// File: rtl/sw_ctrl_pkg.sv
// Shared definitions for the switch debounce / interrupt controller:
// register map and debounce depth limits.
package sw_ctrl_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_DIV  = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } reg_addr_e;

    localparam int DB_MIN = 2;
    localparam int DB_MAX = 8;

    // Keeps an out-of-range debounce depth from producing a zero-width history.
    function automatic int db_depth(input int samples);
        if (samples < DB_MIN) return DB_MIN;
        if (samples > DB_MAX) return DB_MAX;
        return samples;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch channel: two-flop synchroniser, tick-sampled history,
// debounced level and a single-cycle rising-edge strobe.
module sw_debounce_bit
    import sw_ctrl_pkg::*;
#(
    parameter int DB_SAMPLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    output logic deb,
    output logic rise
);

    localparam int DEPTH = db_depth(DB_SAMPLES);

    logic [1:0]       sync;
    logic [DEPTH-1:0] hist;
    logic             deb_next;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        deb_next = deb;
        if (&hist)
            deb_next = 1'b1;
        else if (~|hist)
            deb_next = 1'b0;
    end

    assign rise = deb_next & ~deb;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            hist <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (tick)
                hist <= {hist[DEPTH-2:0], sync[1]};
            deb <= deb_next;
        end
    end

endmodule

// File: rtl/sw_debounce_irq_ctrl.sv
// Avalon-MM switch input port: synchronise and debounce the raw switches,
// latch rising edges and raise a maskable level interrupt.
module sw_debounce_irq_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               DB_SAMPLES = 3,
    parameter int               DIV_W      = 16,
    parameter logic [DIV_W-1:0] DIV_RST    = 16'd49999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_reg;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_clr;
    logic [31:0]      rdata;
    logic             wr;
    logic             tick;

    assign wr       = chipselect & ~write_n;
    assign tick     = (cnt == div);
    assign edge_clr = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(.DB_SAMPLES(DB_SAMPLES)) u_bit (
            .clk  (clk),
            .reset(reset),
            .raw  (in_port[i]),
            .tick (tick),
            .deb  (deb[i]),
            .rise (rise[i])
        );
    end

    always_comb begin
        rdata = '0;
        case (reg_addr_e'(address))
            ADDR_DATA: rdata[WIDTH-1:0] = deb;
            ADDR_DIV:  rdata[DIV_W-1:0] = div;
            ADDR_MASK: rdata[WIDTH-1:0] = mask;
            ADDR_EDGE: rdata[WIDTH-1:0] = edge_reg;
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            div      <= DIV_RST;
            mask     <= '0;
            edge_reg <= '0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            // A DIV write restarts the period so the new rate starts from a clean boundary.
            if (wr && address == ADDR_DIV) begin
                div <= writedata[DIV_W-1:0];
                cnt <= '0;
            end else if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (wr && address == ADDR_MASK)
                mask <= writedata[WIDTH-1:0];

            // A new rise wins over a simultaneous W1C of the same bit.
            edge_reg <= (edge_reg & ~edge_clr) | rise;
            irq      <= |(edge_reg & mask);
            readdata <= rdata;
        end
    end

endmodule

// File: tb/tb_sw_debounce_irq_ctrl.sv
// Directed bench for sw_debounce_irq_ctrl: register reset values, debounce
// timing, glitch rejection, W1C edge capture, interrupt masking and reset.
module tb_sw_debounce_irq_ctrl;
    import sw_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    sw_debounce_irq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        address = a;
        @(negedge clk);
        check(tag, readdata, exp);
    endtask

    initial begin
        logic found;

        reset      = 1'b1;
        address    = ADDR_DIV;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // Reset values and one-cycle read latency
        read_check("rst_data", ADDR_DATA, 32'h0);
        address = ADDR_DIV;
        check("lat_before", readdata, 32'h0);
        @(negedge clk);
        check("lat_after", readdata, 32'd49999);
        read_check("rst_mask", ADDR_MASK, 32'h0);
        read_check("rst_edge", ADDR_EDGE, 32'h0);

        // Mid-count DIV rewrite, then exact debounce timing on bit 0
        write_reg(ADDR_DIV, 32'd7);
        repeat (5) @(negedge clk);
        write_reg(ADDR_DIV, 32'd3);
        in_port[0] = 1'b1;
        address    = ADDR_DATA;
        repeat (13) @(negedge clk);
        check("deb_not_yet", readdata, 32'h0);
        @(negedge clk);
        check("deb_rise_time", readdata, 32'h1);
        read_check("div_readback", ADDR_DIV, 32'd3);
        read_check("edge_bit0", ADDR_EDGE, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);

        // Two-tick glitch on bit 5 is rejected
        in_port[5] = 1'b1;
        repeat (8) @(negedge clk);
        in_port[5] = 1'b0;
        repeat (30) @(negedge clk);
        read_check("glitch_data", ADDR_DATA, 32'h1);
        read_check("glitch_edge", ADDR_EDGE, 32'h1);

        // W1C clear, then masked interrupt on bit 5
        write_reg(ADDR_EDGE, 32'h1);
        read_check("edge_cleared", ADDR_EDGE, 32'h0);
        write_reg(ADDR_MASK, 32'h21);
        read_check("mask_readback", ADDR_MASK, 32'h21);
        check("irq_idle", {31'b0, irq}, 32'h0);

        in_port[5] = 1'b1;
        address    = ADDR_EDGE;
        found      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (irq) begin
                found = 1'b1;
                break;
            end
        end
        check("irq_rise_seen", {31'b0, found}, 32'h1);
        check("edge_with_irq", readdata, 32'h20);

        write_reg(ADDR_EDGE, 32'h0);
        read_check("w0_no_change", ADDR_EDGE, 32'h20);
        check("w0_irq_held", {31'b0, irq}, 32'h1);

        write_reg(ADDR_MASK, 32'h0);
        check("mask_irq_lag", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("mask_irq_off", {31'b0, irq}, 32'h0);
        read_check("mask_keeps_edge", ADDR_EDGE, 32'h20);
        write_reg(ADDR_MASK, 32'h21);
        @(negedge clk);
        check("unmask_irq_on", {31'b0, irq}, 32'h1);

        write_reg(ADDR_EDGE, 32'h20);
        check("w1c_irq_lag", {31'b0, irq}, 32'h1);
        @(negedge clk);
        check("w1c_irq_off", {31'b0, irq}, 32'h0);
        read_check("w1c_edge", ADDR_EDGE, 32'h0);

        // Falling edge not captured; then rise coinciding with W1C of bit 0
        in_port[0] = 1'b0;
        repeat (30) @(negedge clk);
        read_check("fall_data", ADDR_DATA, 32'h20);
        read_check("fall_no_edge", ADDR_EDGE, 32'h0);

        write_reg(ADDR_DIV, 32'd3);
        in_port[0] = 1'b1;
        repeat (12) @(negedge clk);
        address    = ADDR_EDGE;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_check("set_wins", ADDR_EDGE, 32'h1);
        read_check("set_wins_data", ADDR_DATA, 32'h21);
        check("set_wins_irq", {31'b0, irq}, 32'h1);

        // Reset in the middle of debouncing bit 3
        in_port[3] = 1'b1;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        read_check("rst2_data", ADDR_DATA, 32'h0);
        read_check("rst2_div", ADDR_DIV, 32'd49999);
        read_check("rst2_mask", ADDR_MASK, 32'h0);
        read_check("rst2_edge", ADDR_EDGE, 32'h0);
        check("rst2_irq", {31'b0, irq}, 32'h0);

        write_reg(ADDR_DIV, 32'd3);
        address = ADDR_DATA;
        repeat (13) @(negedge clk);
        check("redeb_not_yet", readdata, 32'h0);
        @(negedge clk);
        check("redeb_data", readdata, 32'h29);
        read_check("redeb_edge", ADDR_EDGE, 32'h29);
        check("redeb_irq", {31'b0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
